// File: rtl/snes_audio_fifo.sv
// Stereo sample FIFO between the SNES DSP and the I2S/HDMI audio path.
// Samples are replayed at a fixed rate from a phase accumulator; a FILL/RUN machine primes and recovers from underflow.
module snes_audio_fifo #(
    parameter int ADDR_W   = 5,
    parameter int ACC_W    = 24,
    parameter int INC      = 49995,
    parameter int HEADROOM = 4,
    parameter int PRIME    = 16
) (
    input  logic              WCLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic [15:0]       AUDIO_L,
    input  logic [15:0]       AUDIO_R,
    input  logic              AUDIO_READY,
    output logic              AUDIO_EN,
    output logic [15:0]       OUT_L,
    output logic [15:0]       OUT_R,
    output logic              OUT_VALID,
    output logic              UNDERFLOW,
    output logic              OVERFLOW,
    output logic [ADDR_W:0]   LEVEL,
    output logic              dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PRIME_L    = (ADDR_W+1)'(PRIME);
    localparam logic [ADDR_W:0] EN_LIMIT_L = (ADDR_W+1)'(DEPTH - HEADROOM);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   rptr, wptr;
    logic [ADDR_W:0]     count, count_next;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W:0]      acc_sum;
    logic                tick, push, pop, underflow_next;

    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(INC);
    assign tick      = ENABLE & acc_sum[ACC_W];
    assign LEVEL     = count;
    assign dbg_state = (state == ST_RUN);

    // Handshake: AUDIO_READY is a one-cycle valid strobe from the DSP; AUDIO_EN is the
    // registered ready back to it. A strobe that finds the FIFO full with no pop is dropped.
    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        underflow_next = 1'b0;
        case (state)
            ST_FILL: begin
                if (count >= PRIME_L) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (tick) begin
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        underflow_next = 1'b1;
                        state_next     = ST_FILL;
                    end
                end
            end
            default: state_next = ST_FILL;
        endcase
        push       = AUDIO_READY & ((count != DEPTH_L) | pop);
        count_next = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end

    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) state <= ST_FILL;
        else     state <= state_next;
    end

    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            acc       <= '0;
            OUT_L     <= '0;
            OUT_R     <= '0;
            OUT_VALID <= 1'b0;
            UNDERFLOW <= 1'b0;
            OVERFLOW  <= 1'b0;
            AUDIO_EN  <= 1'b1;
        end else begin
            if (ENABLE) acc <= acc_sum[ACC_W-1:0];
            if (push)   wptr <= wptr + ADDR_W'(1);
            // Underflow and FILL ticks leave OUT_L/R untouched so the last sample repeats.
            if (pop) begin
                rptr           <= rptr + ADDR_W'(1);
                {OUT_L, OUT_R} <= mem[rptr];
            end
            count     <= count_next;
            OUT_VALID <= tick;
            UNDERFLOW <= underflow_next;
            OVERFLOW  <= AUDIO_READY & ~push;
            AUDIO_EN  <= (count_next < EN_LIMIT_L);
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge WCLK) begin
        if (push) mem[wptr] <= {AUDIO_L, AUDIO_R};
    end

endmodule

// File: tb/tb_snes_audio_fifo.sv
// Directed bench for snes_audio_fifo, run with INC = 2^21 so the output strobe falls every 8 enabled cycles.
module tb_snes_audio_fifo;

    logic        clk = 1'b0;
    logic        RST, ENABLE, AUDIO_READY;
    logic [15:0] AUDIO_L, AUDIO_R;
    logic        AUDIO_EN, OUT_VALID, UNDERFLOW, OVERFLOW, dbg_state;
    logic [15:0] OUT_L, OUT_R;
    logic [5:0]  LEVEL;

    int          n_pass  = 0;
    int          n_total = 0;
    int          s;
    logic [31:0] e;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    snes_audio_fifo #(
        .ADDR_W(5), .ACC_W(24), .INC(1 << 21), .HEADROOM(4), .PRIME(16)
    ) dut (
        .WCLK(clk), .RST(RST), .ENABLE(ENABLE),
        .AUDIO_L(AUDIO_L), .AUDIO_R(AUDIO_R), .AUDIO_READY(AUDIO_READY),
        .AUDIO_EN(AUDIO_EN), .OUT_L(OUT_L), .OUT_R(OUT_R), .OUT_VALID(OUT_VALID),
        .UNDERFLOW(UNDERFLOW), .OVERFLOW(OVERFLOW), .LEVEL(LEVEL), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        AUDIO_L     = l;
        AUDIO_R     = r;
        AUDIO_READY = 1'b1;
        cyc();
        AUDIO_READY = 1'b0;
    endtask

    // Seven silent cycles, then a strobe on the eighth, optionally with a push on the tick edge.
    task automatic pop_step(input bit do_push, input logic [15:0] pl, input logic [15:0] pr,
                            input logic [15:0] el, input logic [15:0] er,
                            input int elev, input bit euf, input string tag);
        int q = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (OUT_VALID) q++;
        end
        check({tag, "_quiet"}, 32'(q), 32'd0);
        if (do_push) begin
            AUDIO_L     = pl;
            AUDIO_R     = pr;
            AUDIO_READY = 1'b1;
        end
        cyc();
        AUDIO_READY = 1'b0;
        check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
        check({tag, "_l"}, 32'(OUT_L), 32'(el));
        check({tag, "_r"}, 32'(OUT_R), 32'(er));
        check({tag, "_level"}, 32'(LEVEL), 32'(elev));
        check({tag, "_uf"}, 32'(UNDERFLOW), 32'(euf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; ENABLE = 1'b0; AUDIO_READY = 1'b0; AUDIO_L = '0; AUDIO_R = '0;
        #2 RST = 1'b1;
        #2;
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_en", 32'(AUDIO_EN), 32'd1);
        check("rst_l", 32'(OUT_L), 32'd0);
        check("rst_r", 32'(OUT_R), 32'd0);
        check("rst_valid", 32'(OUT_VALID), 32'd0);
        check("rst_uf", 32'(UNDERFLOW), 32'd0);
        check("rst_of", 32'(OVERFLOW), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        cyc();
        RST = 1'b0;
        cyc();

        // Prime with L=n, R=~n while the accumulator is stopped.
        for (int n = 0; n < 16; n++) begin
            push(16'(n), ~16'(n));
            if (n == 14) begin
                check("prime_level15", 32'(LEVEL), 32'd15);
                check("prime_state15", 32'(dbg_state), 32'd0);
            end
        end
        check("prime_level16", 32'(LEVEL), 32'd16);
        check("prime_state_pre", 32'(dbg_state), 32'd0);
        cyc();
        check("prime_state_run", 32'(dbg_state), 32'd1);

        ENABLE = 1'b1;
        pop_step(0, 16'h0, 16'h0, 16'h0000, 16'hFFFF, 15, 0, "pop0");
        pop_step(0, 16'h0, 16'h0, 16'h0001, 16'hFFFE, 14, 0, "pop1");

        // Accumulator pause: no strobes, outputs hold, phase resumes intact.
        ENABLE = 1'b0;
        s = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (OUT_VALID) s++;
        end
        check("pause_strobes", 32'(s), 32'd0);
        check("pause_hold_l", 32'(OUT_L), 32'h0001);
        ENABLE = 1'b1;

        // Drain; at LEVEL=5 a push lands on the tick edge.
        for (int k = 2; k < 16; k++)
            pop_step(k == 11, 16'h00AA, 16'hFF55, 16'(k), ~16'(k),
                     (k >= 11) ? 16 - k : 15 - k, 0, (k == 11) ? "push_pop" : "drain");
        pop_step(0, 16'h0, 16'h0, 16'h00AA, 16'hFF55, 0, 0, "drain_last");
        pop_step(0, 16'h0, 16'h0, 16'h00AA, 16'hFF55, 0, 1, "underflow");
        check("uf_state_fill", 32'(dbg_state), 32'd0);
        ENABLE = 1'b0;
        cyc();
        check("uf_pulse_end", 32'(UNDERFLOW), 32'd0);
        check("uf_valid_end", 32'(OUT_VALID), 32'd0);

        // FILL after underflow: ticks strobe but do not pop.
        for (int i = 0; i < 3; i++) begin
            push(16'h0100 + 16'(i), 16'h8000 | 16'(i));
            exp_q.push_back({16'h0100 + 16'(i), 16'h8000 | 16'(i)});
        end
        ENABLE = 1'b1;
        pop_step(0, 16'h0, 16'h0, 16'h00AA, 16'hFF55, 3, 0, "fill_hold");
        check("fill_hold_state", 32'(dbg_state), 32'd0);
        ENABLE = 1'b0;

        // Fill to the top: backpressure at 28, drop at 32.
        for (int i = 3; i < 32; i++) begin
            push(16'h0100 + 16'(i), 16'h8000 | 16'(i));
            exp_q.push_back({16'h0100 + 16'(i), 16'h8000 | 16'(i)});
            if (i == 26) check("en_at27", 32'(AUDIO_EN), 32'd1);
            if (i == 27) begin
                check("level28", 32'(LEVEL), 32'd28);
                check("en_at28", 32'(AUDIO_EN), 32'd0);
            end
        end
        check("full_level", 32'(LEVEL), 32'd32);
        check("full_state", 32'(dbg_state), 32'd1);
        push(16'hDEAD, 16'hBEEF);
        check("of_pulse", 32'(OVERFLOW), 32'd1);
        check("of_level", 32'(LEVEL), 32'd32);
        cyc();
        check("of_pulse_end", 32'(OVERFLOW), 32'd0);

        ENABLE = 1'b1;
        for (int j = 0; j < 32; j++) begin
            e = exp_q.pop_front();
            pop_step(0, 16'h0, 16'h0, e[31:16], e[15:0], 31 - j, 0, "sb_drain");
        end
        ENABLE = 1'b0;
        check("drain_en", 32'(AUDIO_EN), 32'd1);

        // Asynchronous reset in the middle of a cycle with data buffered.
        for (int i = 0; i < 10; i++) push(16'h0200 + 16'(i), 16'h0300 + 16'(i));
        check("pre_rst_level", 32'(LEVEL), 32'd10);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_level", 32'(LEVEL), 32'd0);
        check("mid_rst_en", 32'(AUDIO_EN), 32'd1);
        check("mid_rst_l", 32'(OUT_L), 32'd0);
        check("mid_rst_r", 32'(OUT_R), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        cyc();
        RST = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
